stream_pack: RTL and testbench
==============================

Name: stream_pack

Overview:
- Byte-to-word deserializer for the data+valid+ready stream protocol.
- Collects N_BYTES consecutive bytes from a byte stream and emits them as one wide word on the same handshake protocol.
- Sits downstream of byte-wide sources (FTDI/USB receive path, stream buffers) and feeds word-oriented consumers such as register/command decoders.
- Single clock domain.

Parameters:
- N_BYTES, 4, bytes per output word; legal range 2..8.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_data  input  8  upstream byte.
- i_valid  input  1  upstream byte valid.
- o_ready  output  1  block accepts upstream byte this cycle.
- o_data  output  8*N_BYTES  downstream word; byte k occupies bits [8k+7:8k].
- o_valid  output  1  downstream word valid.
- i_ready  input  1  downstream accepts word.
- i_flush  input  1  flush request (only with STREAM_PACK_FLUSH_EN).
- o_nbytes  output  $clog2(N_BYTES+1)  number of valid bytes in o_data (only with STREAM_PACK_FLUSH_EN).

Behaviour:
- Clock/reset: one clock, i_clk; i_rst is asynchronous and active-high.
- Transfer definitions: upstream transfer = i_valid && o_ready; downstream transfer = o_valid && i_ready.
- State: accumulator acc[8*N_BYTES-1:0], byte counter cnt (0..N_BYTES-1), output register out_data, out_valid.
- Reset values: acc=0, cnt=0, out_data=0, out_valid=0, hence o_valid=0 and o_data=0. o_ready=1 after reset.
- Byte order: little-endian. The first byte accepted after reset or after a word completes goes to byte 0 (bits [7:0]).
- Upstream transfer with cnt < N_BYTES-1: acc byte[cnt] <= i_data; cnt <= cnt+1.
- Upstream transfer with cnt == N_BYTES-1:
  - out_data <= acc with byte[N_BYTES-1] replaced by i_data;
  - out_valid <= 1; cnt <= 0; acc <= 0.
- Latency: the final byte is accepted on edge t, and o_valid=1 with the complete word is visible after edge t.
- Downstream transfer with no new completion on the same edge: out_valid <= 0.
- Simultaneous downstream transfer and word completion: out_valid stays 1 and out_data takes the new word. No bubble.
- o_ready (combinational):
  - 0 if cnt == N_BYTES-1 && out_valid && !i_ready;
  - otherwise 1.
  - Bytes 0..N_BYTES-2 of the next word are always accepted while the previous word waits downstream.
- Throughput: 1 byte/cycle sustained with i_ready=1, i.e. one word every N_BYTES cycles.
- o_data and o_valid are registered. The only combinational path is i_ready -> o_ready, and only when cnt == N_BYTES-1.
- Stability: o_data is held stable while o_valid && !i_ready.
- Partial state: a partial word persists indefinitely if upstream stalls. Bytes are never dropped or duplicated.
- Reset mid-operation: acc, cnt and out_valid clear immediately, and any partial or pending word is discarded.

Optional Feature:
- Macro: STREAM_PACK_FLUSH_EN.
- With the macro, ports i_flush and o_nbytes exist, plus an internal flush_pend flag (reset 0).
- i_flush sampled 1 with cnt > 0 (after counting any byte accepted on the same edge): the partial word is emitted.
  - Unfilled bytes are 0 and o_nbytes = number of filled bytes.
  - cnt is set to 0.
  - If out_valid && !i_ready, the flush is held in flush_pend instead and o_ready=0 until the partial word is loaded.
- Flush ordering:
  - A byte accepted on the same edge as i_flush is included before the flush takes effect.
  - If that byte completes a word, the flush sees cnt=0 and has no effect.
- i_flush with cnt == 0: ignored, and no empty word is emitted.
- Full words report o_nbytes = N_BYTES. o_nbytes reset value is 0.
- Without the macro: no flush logic, no i_flush/o_nbytes ports, and partial words are only cleared by reset.

Test Plan:
- N_BYTES=4, i_ready=1, bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> one o_valid pulse with o_data=0x44332211, one cycle after the 0x44 transfer.
- Continuous bytes 0x00..0x0B, i_ready=1 -> words 0x03020100, 0x07060504, 0x0B0A0908 with no stalls; o_ready stays 1 throughout.
- i_ready=0 after first word completes, feed 4 more bytes:
  - o_ready drops only when cnt=3;
  - first word is held stable;
  - raising i_ready yields back-to-back words with no loss.
- Random i_valid/i_ready throttling over 10k bytes -> output word stream equals scoreboard packing of input bytes, with o_data stable while stalled.
- Assert i_rst mid-word (cnt=2) with out_valid=1 -> o_valid=0 and o_data=0 immediately; the next 4 bytes form a fresh aligned word.
- STREAM_PACK_FLUSH_EN:
  - bytes 0xAA,0xBB then i_flush -> o_data=0x0000BBAA, o_nbytes=2;
  - i_flush with cnt=0 -> no output.

Source files
------------

// File: rtl/stream_pack.sv
// stream_pack: byte-to-word deserializer (little-endian) on a data/valid/ready stream.
// Optional partial-word flush is compiled in with `define STREAM_PACK_FLUSH_EN.
//
// Handshake: a transfer happens on the rising edge where valid && ready are both
// high. The sender holds data/valid steady until the transfer. Ready may depend
// on the consumer's ready, but valid never depends on ready.
module stream_pack #(
  parameter int N_BYTES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [8*N_BYTES-1:0]   o_data,
  output logic                   o_valid,
  input  logic                   i_ready
`ifdef STREAM_PACK_FLUSH_EN
  ,
  input  logic                   i_flush,
  output logic [$clog2(N_BYTES+1)-1:0] o_nbytes
`endif
);

  localparam int CW = $clog2(N_BYTES);
  localparam int W  = 8 * N_BYTES;
  localparam logic [CW-1:0] LAST = CW'(N_BYTES - 1);

  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_out_data;
  logic          r_out_valid;

  logic [W-1:0]  w_acc_ins;
  logic [W-1:0]  w_acc_n;
  logic [CW-1:0] w_cnt_n;
  logic [W-1:0]  w_out_data_n;
  logic          w_out_valid_n;
  logic          w_last;
  logic          w_up;
  logic          w_complete;
  logic          w_stall_last;

`ifdef STREAM_PACK_FLUSH_EN
  localparam int NBW = $clog2(N_BYTES + 1);
  logic [NBW-1:0] r_nbytes;
  logic [NBW-1:0] w_nbytes_n;
  logic           r_flush_pend;
  logic           w_flush_pend_n;
  logic           w_flush_req;
`endif

  assign w_last       = (r_cnt == LAST);
  // Only the final byte of a word needs the output slot, so only it waits on i_ready.
  assign w_stall_last = w_last && r_out_valid && !i_ready;

`ifdef STREAM_PACK_FLUSH_EN
  assign o_ready  = !(w_stall_last || r_flush_pend);
  assign o_nbytes = r_nbytes;
`else
  assign o_ready  = !w_stall_last;
`endif

  assign w_up       = i_valid && o_ready;
  assign w_complete = w_up && w_last;
  assign o_data     = r_out_data;
  assign o_valid    = r_out_valid;

  always_comb begin
    w_acc_ins = r_acc;
    for (int k = 0; k < N_BYTES; k++) begin
      if (w_up && (r_cnt == CW'(k))) w_acc_ins[8*k +: 8] = i_data;
    end

    w_acc_n       = w_acc_ins;
    w_cnt_n       = r_cnt;
    w_out_data_n  = r_out_data;
    w_out_valid_n = r_out_valid && !i_ready;
`ifdef STREAM_PACK_FLUSH_EN
    w_nbytes_n     = r_nbytes;
    w_flush_pend_n = 1'b0;
    w_flush_req    = 1'b0;
`endif

    if (w_up) w_cnt_n = w_last ? '0 : r_cnt + CW'(1);

    if (w_complete) begin
      w_out_data_n  = w_acc_ins;
      w_out_valid_n = 1'b1;
      w_acc_n       = '0;
`ifdef STREAM_PACK_FLUSH_EN
      w_nbytes_n    = NBW'(N_BYTES);
`endif
    end

`ifdef STREAM_PACK_FLUSH_EN
    // The flush sees the count after any byte accepted on this edge.
    w_flush_req = (i_flush || r_flush_pend) && (w_cnt_n != '0);
    if (w_flush_req) begin
      if (r_out_valid && !i_ready) begin
        w_flush_pend_n = 1'b1;
      end else begin
        w_out_data_n  = w_acc_ins;
        w_out_valid_n = 1'b1;
        w_nbytes_n    = NBW'(w_cnt_n);
        w_acc_n       = '0;
        w_cnt_n       = '0;
      end
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_n;
      r_cnt       <= w_cnt_n;
      r_out_data  <= w_out_data_n;
      r_out_valid <= w_out_valid_n;
    end
  end

`ifdef STREAM_PACK_FLUSH_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_nbytes     <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_nbytes     <= w_nbytes_n;
      r_flush_pend <= w_flush_pend_n;
    end
  end
`endif

endmodule

// File: tb/tb_stream_pack.sv
// Self-checking bench for stream_pack (N_BYTES=4): directed steps plus a random
// throttled run, with a word scoreboard fed from the accepted bytes.
module tb_stream_pack;
  localparam int N = 4;
  localparam int W = 8 * N;

  logic         i_clk;
  logic         i_rst;
  logic [7:0]   i_data;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         i_ready;
`ifdef STREAM_PACK_FLUSH_EN
  logic         i_flush;
  logic [2:0]   o_nbytes;
`endif

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int words  = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   part_q[$];

  stream_pack #(.N_BYTES(N)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready)
`ifdef STREAM_PACK_FLUSH_EN
    ,
    .i_flush (i_flush),
    .o_nbytes(o_nbytes)
`endif
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // scoreboard model
  task automatic model_byte(input logic [7:0] b);
    logic [W-1:0] w;
    part_q.push_back(b);
    if (part_q.size() == N) begin
      w = '0;
      for (int k = 0; k < N; k++) w[8*k +: 8] = part_q[k];
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  task automatic model_flush();
    logic [W-1:0] w;
    if (part_q.size() != 0) begin
      w = '0;
      for (int k = 0; k < part_q.size(); k++) w[8*k +: 8] = part_q[k];
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic send_byte(input logic [7:0] b);
    int   waits;
    logic acc;
    i_valid = 1'b1;
    i_data  = b;
    waits   = 0;
    acc     = 1'b0;
    while (!acc && waits < 200) begin
      @(negedge i_clk);
      if (o_ready) begin
        acc = 1'b1;
        model_byte(b);
      end else begin
        waits++;
        stalls++;
      end
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    chk("byte_accept_timeout", W'(acc), W'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_valid) && n < 500) begin
      idle(1);
      n++;
    end
    chk("drain_queue_empty", W'(exp_q.size()), W'(0));
  endtask

  // monitor: every presented word must match the scoreboard head (covers stability)
  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_word got %0h exp none", o_data);
      end else begin
        chk("word", o_data, exp_q[0]);
        if (i_ready) begin
          void'(exp_q.pop_front());
          words++;
        end
      end
    end
  end

  logic done_rand;

  initial begin
    int s0;
    i_rst     = 1'b1;
    i_data    = '0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    done_rand = 1'b0;
`ifdef STREAM_PACK_FLUSH_EN
    i_flush   = 1'b0;
`endif
    idle(2);
    chk("reset_o_valid", W'(o_valid), W'(0));
    chk("reset_o_data", o_data, W'(0));
    chk("reset_o_ready", W'(o_ready), W'(1));
`ifdef STREAM_PACK_FLUSH_EN
    chk("reset_o_nbytes", W'(o_nbytes), W'(0));
`endif
    i_rst = 1'b0;
    idle(1);

    // single word, latency one edge after the last byte
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("t1_no_early_valid", W'(o_valid), W'(0));
    send_byte(8'h44);
    chk("t1_valid", W'(o_valid), W'(1));
    chk("t1_data", o_data, 32'h44332211);
    idle(1);
    chk("t1_single_pulse", W'(o_valid), W'(0));

    // continuous stream, no stalls
    words  = 0;
    stalls = 0;
    for (int i = 0; i < 12; i++) send_byte(8'(i));
    wait_drain();
    chk("t2_words", W'(words), W'(3));
    chk("t2_no_stalls", W'(stalls), W'(0));

    // downstream back-pressure
    send_byte(8'hA0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    i_ready = 1'b0;
    send_byte(8'hA3);
    s0 = stalls;
    send_byte(8'hB0);
    send_byte(8'hB1);
    send_byte(8'hB2);
    chk("t3_ready_while_pending", W'(stalls), W'(s0));
    i_valid = 1'b1;
    i_data  = 8'hB3;
    repeat (3) begin
      idle(1);
      chk("t3_ready_low", W'(o_ready), W'(0));
      chk("t3_hold_valid", W'(o_valid), W'(1));
      chk("t3_hold_data", o_data, 32'hA3A2A1A0);
    end
    i_ready = 1'b1;
    send_byte(8'hB3);
    chk("t3_b2b_valid", W'(o_valid), W'(1));
    chk("t3_b2b_data", o_data, 32'hB3B2B1B0);
    wait_drain();

    // random throttling on both sides
    words = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send_byte(8'($urandom_range(0, 255)));
        end
        done_rand = 1'b1;
      end
      begin
        while (!done_rand) begin
          @(posedge i_clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
        i_ready = 1'b1;
      end
    join
    wait_drain();
    chk("t4_words", W'(words), W'(2500));
    chk("t4_no_partial", W'(part_q.size()), W'(0));

    // reset mid-word with a pending output word
    i_ready = 1'b0;
    send_byte(8'hC0);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    i_rst = 1'b1;
    exp_q.delete();
    part_q.delete();
    #1;
    chk("t5_rst_o_valid", W'(o_valid), W'(0));
    chk("t5_rst_o_data", o_data, W'(0));
    idle(1);
    i_rst   = 1'b0;
    i_ready = 1'b1;
    send_byte(8'hD0);
    send_byte(8'hD1);
    send_byte(8'hD2);
    send_byte(8'hD3);
    chk("t5_fresh_valid", W'(o_valid), W'(1));
    chk("t5_fresh_data", o_data, 32'hD3D2D1D0);
    wait_drain();

`ifdef STREAM_PACK_FLUSH_EN
    // partial-word flush
    send_byte(8'hAA);
    send_byte(8'hBB);
    i_flush = 1'b1;
    model_flush();
    idle(1);
    i_flush = 1'b0;
    chk("f_valid", W'(o_valid), W'(1));
    chk("f_data", o_data, 32'h0000BBAA);
    chk("f_nbytes", W'(o_nbytes), W'(2));
    idle(1);
    chk("f_single_pulse", W'(o_valid), W'(0));
    i_flush = 1'b1;
    idle(1);
    i_flush = 1'b0;
    chk("f_empty_ignored", W'(o_valid), W'(0));
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    chk("f_full_nbytes", W'(o_nbytes), W'(4));
    chk("f_full_data", o_data, 32'h04030201);
    wait_drain();
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
